inv_mix_columns: RTL and testbench

INV_MIX_COLUMNS -- requirements
Module: inv_mix_columns

---
 rtl/aes_pkg.sv | 20 ++
 rtl/inv_mix_column.sv | 37 +++
 rtl/inv_mix_columns.sv | 89 ++++++++
 tb/tb_inv_mix_columns.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: field widths, GF(2^8) reduction polynomial,
// xtime helper and the control FSM state type.
package aes_pkg;

  localparam int WORD_SIZE = 8;
  localparam int STATE_BITS = 128;
  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x in GF(2^8); the reduction is folded into the shift.
  function automatic logic [WORD_SIZE-1:0] xtime(input logic [WORD_SIZE-1:0] b);
    xtime = {b[WORD_SIZE-2:0], 1'b0} ^ (b[WORD_SIZE-1] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns transform of one 32-bit column (row 0 in the MSB).
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [WORD_SIZE-1:0] a   [4];
  logic [WORD_SIZE-1:0] m09 [4];
  logic [WORD_SIZE-1:0] m0b [4];
  logic [WORD_SIZE-1:0] m0d [4];
  logic [WORD_SIZE-1:0] m0e [4];

  // Each constant is a sum of powers of x built from three xtime steps.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      logic [WORD_SIZE-1:0] x2, x4, x8;
      a[r]   = col_in[31-8*r -: 8];
      x2     = xtime(a[r]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m09[r] = x8 ^ a[r];
      m0b[r] = x8 ^ x2 ^ a[r];
      m0d[r] = x8 ^ x4 ^ a[r];
      m0e[r] = x8 ^ x4 ^ x2;
    end
  end

  always_comb begin
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      col_out[31-8*r -: 8] = m0e[r] ^ m0b[(r+1)%4] ^ m0d[(r+2)%4] ^ m09[(r+3)%4];
    end
  end

endmodule

// File: rtl/inv_mix_columns.sv
// Iterative AES InvMixColumns: one shared column unit, four BUSY cycles per state,
// result held in DONE until out_ready; no new state accepted outside IDLE.
module inv_mix_columns
  import aes_pkg::*;
#(
  parameter int word_size  = 8,
  parameter int array_size = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [word_size*array_size-1:0] state_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [word_size*array_size-1:0] state_out
);

  state_t                state, state_next;
  logic [1:0]            col;
  logic [STATE_BITS-1:0] in_reg;
  logic [STATE_BITS-1:0] result;
  logic [STATE_BITS-1:0] result_next;
  logic [31:0]           col_in;
  logic [31:0]           col_out;

  inv_mix_column u_col (
    .col_in  (col_in),
    .col_out (col_out)
  );

  // Column select and write-back share the same counter.
  always_comb begin
    col_in      = in_reg[127:96];
    result_next = result;
    case (col)
      2'd0: begin col_in = in_reg[127:96]; result_next[127:96] = col_out; end
      2'd1: begin col_in = in_reg[95:64];  result_next[95:64]  = col_out; end
      2'd2: begin col_in = in_reg[63:32];  result_next[63:32]  = col_out; end
      default: begin col_in = in_reg[31:0]; result_next[31:0] = col_out; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (col == 2'd3) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= 2'd0;
      in_reg    <= '0;
      result    <= '0;
      state_out <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        in_reg <= state_in;
        col    <= 2'd0;
      end
      if (state == BUSY) begin
        result <= result_next;
        col    <= col + 2'd1;
        // The last column goes straight into state_out, bypassing result.
        if (col == 2'd3) state_out <= result_next;
      end
    end
  end

endmodule

// File: tb/tb_inv_mix_columns.sv
// Directed bench for inv_mix_columns: known vectors, backpressure, mid-op reset,
// streaming cadence and a random round trip through a forward MixColumns model.
module tb_inv_mix_columns;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] V2_OUT = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V3_IN  = 128'h4d7ebdf8_8e4da1bc_d5d5d7d6_9fdc589d;
  localparam logic [127:0] V3_OUT = 128'h2d26314c_db135345_d4d4d4d5_f20a225c;

  inv_mix_columns #(.word_size(8), .array_size(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = xt(a[r]) ^ (xt(a[(r+1)%4]) ^ a[(r+1)%4])
                               ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  // Starts and ends on a falling edge; leaves the DUT in DONE when hold is set.
  task automatic run_txn(input string tag, input logic [127:0] din,
                         input logic [127:0] dexp, input logic hold);
    out_ready = ~hold;
    in_valid  = 1'b1;
    state_in  = din;
    @(negedge clk);
    in_valid = 1'b0;
    chk1({tag, ".busy_in_ready"}, in_ready, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk1($sformatf("%s.no_early_valid%0d", tag, k), out_valid, 1'b0);
    end
    @(negedge clk);
    chk1({tag, ".out_valid"}, out_valid, 1'b1);
    chk({tag, ".state_out"}, state_out, dexp);
    if (!hold) begin
      @(negedge clk);
      chk1({tag, ".back_idle"}, in_ready, 1'b1);
    end
  endtask

  initial begin
    logic [127:0] rnd, junk;
    logic [127:0] s_in [3];
    logic [127:0] s_exp [3];
    int           t_out [3];
    int           idx, nout;
    logic         acc, prev_v, seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; state_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk1("reset.in_ready", in_ready, 1'b1);
    chk1("reset.out_valid", out_valid, 1'b0);
    chk("reset.state_out", state_out, 128'h0);

    run_txn("vec1", V1_IN, V1_OUT, 1'b0);
    chk("vec1.hold_idle", state_out, V1_OUT);

    // Backpressure: DONE must ignore in_valid and keep its result stable.
    run_txn("vec2", V2_IN, V2_OUT, 1'b1);
    for (int i = 0; i < 5; i++) begin
      junk     = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_valid = (i % 2 == 0);
      state_in = junk;
      @(negedge clk);
      chk1($sformatf("bp%0d.out_valid", i), out_valid, 1'b1);
      chk1($sformatf("bp%0d.in_ready", i), in_ready, 1'b0);
      chk($sformatf("bp%0d.state_out", i), state_out, V2_OUT);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk1("bp.release_in_ready", in_ready, 1'b1);
    chk1("bp.release_out_valid", out_valid, 1'b0);
    chk("bp.release_state_out", state_out, V2_OUT);
    @(negedge clk);
    chk1("bp.no_capture", in_ready, 1'b1);

    // Reset while col == 2.
    in_valid = 1'b1;
    state_in = V2_IN;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk1("midrst.in_ready", in_ready, 1'b1);
    chk1("midrst.out_valid", out_valid, 1'b0);
    chk("midrst.state_out", state_out, 128'h0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk1("midrst.no_pulse", seen, 1'b0);
    run_txn("midrst.vec1", V1_IN, V1_OUT, 1'b0);

    // Streaming with both handshakes held high.
    s_in[0] = V1_IN; s_in[1] = V2_IN; s_in[2] = V3_IN;
    s_exp[0] = V1_OUT; s_exp[1] = V2_OUT; s_exp[2] = V3_OUT;
    t_out[0] = 0; t_out[1] = 0; t_out[2] = 0;
    idx = 0; nout = 0; prev_v = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    state_in  = s_in[0];
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc = in_ready && in_valid;
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < 3) state_in = s_in[idx];
        else         in_valid = 1'b0;
      end
      if (out_valid) begin
        if (prev_v) chk1($sformatf("stream.single_cycle@%0d", cyc), prev_v, 1'b0);
        if (nout < 3) begin
          chk($sformatf("stream.out%0d", nout), state_out, s_exp[nout]);
          t_out[nout] = cyc;
        end
        nout++;
      end
      prev_v = out_valid;
    end
    chk("stream.count", 128'(nout), 128'd3);
    chk("stream.gap01", 128'(t_out[1] - t_out[0]), 128'd6);
    chk("stream.gap12", 128'(t_out[2] - t_out[1]), 128'd6);

    // Random round trip through the forward transform.
    for (int i = 0; i < 1000; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_txn($sformatf("rt%0d", i), fwd_mix(rnd), rnd, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
